conv_frame_host: RTL and testbench
==================================

// Module: conv_frame_host
// PURPOSE
//  Host-side partner of the 8x8 / 3x3 convolution engine. On start, reads a 64-pixel
//  frame from image RAM, transmits it as an in_st pulse plus 64 bytes on din, waits for
//  the engine's out_st, and captures the 36 results into a 6x6 result buffer with a read
//  port. Sits between the image/result memories and the engine in the top-level datapath.
// PARAMETERS
//  PIX_W    8     pixel width (din, img_rdata)
//  RES_W    16    result width (dout, res_rdata)
//  N_IN     64    pixels per frame (8x8)
//  N_OUT    36    results per frame (6x6)
//  TIMEOUT  4096  max cycles from last din byte to out_st before abort
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  rst        in   1      synchronous reset, active-high
//  start      in   1      1-cycle request to process one frame
//  busy       out  1      high from accepted start until DONE/abort
//  done       out  1      sticky: frame captured OK; cleared by next accepted start
//  timeout    out  1      sticky: out_st never arrived; cleared by next accepted start
//  img_addr   out  6      image RAM read address
//  img_rdata  in   PIX_W  image RAM data, 1-cycle read latency
//  in_st      out  1      frame-start pulse to engine
//  din        out  PIX_W  pixel stream to engine, registered
//  out_st     in   1      result-start pulse from engine
//  dout       in   RES_W  result stream from engine
//  res_addr   in   6      result buffer read address (0..35, row-major)
//  res_rdata  out  RES_W  result buffer data, combinational read
// BEHAVIOUR
//  Reset: busy=0, done=0, timeout=0, in_st=0, din=0, img_addr=0, FSM=IDLE, counters=0.
//   Result buffer contents are not cleared by reset.
//  FSM: IDLE -> FETCH -> SEND -> WAIT -> CAPTURE -> IDLE.
//  IDLE: start=1 accepted; clears done/timeout, sets busy, goes to FETCH. start is ignored
//   in every other state.
//  FETCH (1 cycle, T-1): img_addr=0.
//  SEND: in_st=1 in cycle T only. img_addr=k in cycle T-1+k; din=pixel k in cycle T+1+k,
//   k=0..63. din=0 whenever no pixel is being sent. Last byte at T+64, then WAIT.
//  WAIT: timeout counter starts at 0 on entry and increments each cycle. out_st=1 -> CAPTURE.
//   If the counter reaches TIMEOUT-1 with no out_st: timeout=1, busy=0, go to IDLE.
//   out_st seen outside WAIT is ignored.
//  CAPTURE: out_st is high in engine cycle S; result k is on dout in cycle S+1+k.
//   The buffer writes entry k at the edge ending cycle S+1+k, k=0..35. After entry 35:
//   done=1, busy=0, go to IDLE. out_st re-asserting during CAPTURE is ignored.
//  Widths: dout is stored unmodified (RES_W bits); pixels are passed through unmodified.
//  res_rdata = buf[res_addr] at all times, including mid-capture (partial/stale data).
//   res_addr>35 returns 0.
//  Mid-operation reset: next cycle in_st=0, din=0, busy=0, FSM=IDLE. A partially sent
//   frame is abandoned; the engine's recovery is outside this block.
//  start and rst in the same cycle: rst wins.
// TESTING
//  1 Ramp RAM (pix k=k), pulse start -> in_st exactly 1 cycle; din 0x00..0x3F in
//    cycles T+1..T+64; img_addr 0..63 one cycle ahead of the RAM data.
//  2 With the engine model and all pixels=16 -> 36 captures of 0x0800, done=1,
//    busy=0, res_rdata[0]=res_rdata[35]=0x0800.
//  3 Engine model that never asserts out_st -> timeout=1 and busy=0 exactly TIMEOUT
//    cycles after WAIT entry; done=0.
//  4 start pulsed during SEND and CAPTURE -> ignored (one in_st per frame); second
//    start after done -> new frame, done clears on acceptance.
//  5 rst at k=20 of SEND -> next cycle in_st=0, din=0, busy=0; a later start re-sends
//    from pixel 0.
//  6 Spurious out_st during SEND -> no capture, FSM proceeds to WAIT; the real out_st
//    later captures correctly.

Source files
------------

// File: rtl/conv_frame_host.sv
// Host-side sequencer for the 8x8/3x3 convolution engine: streams one frame from
// image RAM to the engine and captures the 6x6 result block into a readable buffer.
module conv_frame_host #(
   parameter int PIX_W   = 8,
   parameter int RES_W   = 16,
   parameter int N_IN    = 64,
   parameter int N_OUT   = 36,
   parameter int TIMEOUT = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic [5:0]       img_addr,
   input  logic [PIX_W-1:0] img_rdata,
   output logic             in_st,
   output logic [PIX_W-1:0] din,
   input  logic             out_st,
   input  logic [RES_W-1:0] dout,
   input  logic [5:0]       res_addr,
   output logic [RES_W-1:0] res_rdata
);

   localparam int TO_W  = $clog2(TIMEOUT);
   localparam int CNT_W = (TO_W > 7) ? TO_W : 7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SEND,
      ST_WAIT,
      ST_CAPTURE
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               timeout_q, timeout_d;
   logic               in_st_q, in_st_d;
   logic [PIX_W-1:0]   din_q, din_d;
   logic [5:0]         img_addr_q, img_addr_d;
   logic               mem_we;
   logic [5:0]         mem_waddr;
   logic [RES_W-1:0]   res_mem_q [N_OUT];

   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      done_d     = done_q;
      timeout_d  = timeout_q;
      img_addr_d = img_addr_q;
      in_st_d    = 1'b0;
      din_d      = '0;
      mem_we     = 1'b0;
      mem_waddr  = cnt_q[5:0];

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               done_d     = 1'b0;
               timeout_d  = 1'b0;
               busy_d     = 1'b1;
               img_addr_d = '0;
               cnt_d      = '0;
               state_d    = ST_FETCH;
            end
         end
         ST_FETCH: begin
            in_st_d    = 1'b1;
            img_addr_d = img_addr_q + 6'd1;
            cnt_d      = '0;
            state_d    = ST_SEND;
         end
         ST_SEND: begin
            // RAM data lags the address by one cycle, so cnt_q indexes the pixel now on img_rdata
            cnt_d = cnt_q + 1'b1;
            if (cnt_q < CNT_W'(N_IN)) din_d = img_rdata;
            if (img_addr_q != 6'(N_IN - 1)) img_addr_d = img_addr_q + 6'd1;
            if (cnt_q == CNT_W'(N_IN)) begin
               cnt_d   = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (out_st) begin
               cnt_d   = '0;
               state_d = ST_CAPTURE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               timeout_d = 1'b1;
               busy_d    = 1'b0;
               cnt_d     = '0;
               state_d   = ST_IDLE;
            end
         end
         ST_CAPTURE: begin
            mem_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(N_OUT - 1)) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
         in_st_q    <= 1'b0;
         din_q      <= '0;
         img_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         timeout_q  <= timeout_d;
         in_st_q    <= in_st_d;
         din_q      <= din_d;
         img_addr_q <= img_addr_d;
      end
   end

   // NOTE: the result buffer is deliberately left out of reset so it maps onto plain RAM/regfile.
   always_ff @(posedge clk) begin
      if (mem_we) res_mem_q[mem_waddr] <= dout;
   end

   always_comb begin
      res_rdata = '0;
      if (res_addr < 6'(N_OUT)) res_rdata = res_mem_q[res_addr];
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign timeout  = timeout_q;
   assign in_st    = in_st_q;
   assign din      = din_q;
   assign img_addr = img_addr_q;

endmodule

// File: tb/tb_conv_frame_host.sv
// Self-checking bench for conv_frame_host: image RAM and engine models, a result
// scoreboard, a table of frame scenarios and hand-written corner-case sequences.
module tb_conv_frame_host;

   localparam int PIX_W   = 8;
   localparam int RES_W   = 16;
   localparam int N_IN    = 64;
   localparam int N_OUT   = 36;
   localparam int TIMEOUT = 4096;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             busy, done, timeout;
   logic [5:0]       img_addr;
   logic [PIX_W-1:0] img_rdata;
   logic             in_st;
   logic [PIX_W-1:0] din;
   logic             out_st;
   logic [RES_W-1:0] dout;
   logic [5:0]       res_addr;
   logic [RES_W-1:0] res_rdata;

   conv_frame_host #(
      .PIX_W(PIX_W), .RES_W(RES_W), .N_IN(N_IN), .N_OUT(N_OUT), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .timeout(timeout),
      .img_addr(img_addr), .img_rdata(img_rdata), .in_st(in_st), .din(din),
      .out_st(out_st), .dout(dout), .res_addr(res_addr), .res_rdata(res_rdata)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   logic [PIX_W-1:0] img_mem [N_IN];
   logic [PIX_W-1:0] rx_pix  [N_IN];
   logic [RES_W-1:0] sb [$];

   // Image RAM with one cycle of read latency
   always @(posedge clk) img_rdata <= img_mem[img_addr];

   // 3x3 smoothing kernel (1 2 1 / 2 4 2 / 1 2 1) scaled by 8, on the bench image or on received pixels
   function automatic int conv_at(input bit use_rx, input int k);
      int r, c, acc, p, idx;
      r   = k / 6;
      c   = k % 6;
      acc = 0;
      for (int dr = 0; dr < 3; dr++) begin
         for (int dc = 0; dc < 3; dc++) begin
            idx = (r + dr) * 8 + c + dc;
            p   = use_rx ? int'(rx_pix[idx]) : int'(img_mem[idx]);
            acc += p * ((dr == 1) ? 2 : 1) * ((dc == 1) ? 2 : 1);
         end
      end
      return acc * 8;
   endfunction

   // Engine model: receives the frame, then answers with out_st and 36 results
   int rx_k = -1, wait_k = -1, res_k = -1, in_st_total = 0;
   bit post_k = 1'b0;
   bit eng_respond = 1'b1;
   int eng_delay = 0;
   int spur_rx = -1;

   always @(negedge clk) begin
      out_st = 1'b0;
      dout   = '0;
      if (rst) begin
         rx_k   = -1;
         wait_k = -1;
         res_k  = -1;
         post_k = 1'b0;
      end else begin
         if (res_k >= 0) begin
            dout  = RES_W'(conv_at(1'b1, res_k));
            res_k = (res_k == N_OUT - 1) ? -1 : res_k + 1;
         end
         if (wait_k == 0) begin
            out_st = 1'b1;
            wait_k = -1;
            res_k  = 0;
         end else if (wait_k > 0) begin
            wait_k--;
         end
         if (post_k) begin
            check("din_zero_after_frame", 32'(din), 32'h0);
            post_k = 1'b0;
         end
         if (in_st) begin
            in_st_total++;
            check("din_zero_at_in_st", 32'(din), 32'h0);
            check("img_addr_at_in_st", 32'(img_addr), 32'h1);
            rx_k = 0;
         end else if (rx_k >= 0) begin
            check($sformatf("din_pixel[%0d]", rx_k), 32'(din), 32'(img_mem[rx_k]));
            if (rx_k <= N_IN - 3)
               check($sformatf("img_addr_lead[%0d]", rx_k), 32'(img_addr), rx_k + 2);
            if (rx_k == spur_rx) out_st = 1'b1;
            rx_pix[rx_k] = din;
            if (rx_k == N_IN - 1) begin
               rx_k   = -1;
               post_k = 1'b1;
               if (eng_respond) wait_k = eng_delay;
            end else begin
               rx_k++;
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic fill_img(input int mode);
      for (int k = 0; k < N_IN; k++) begin
         case (mode)
            0:       img_mem[k] = 8'(k);
            1:       img_mem[k] = 8'd16;
            default: img_mem[k] = 8'($urandom_range(0, 255));
         endcase
      end
   endtask

   task automatic push_expected();
      for (int k = 0; k < N_OUT; k++) sb.push_back(RES_W'(conv_at(1'b0, k)));
   endtask

   int frame_base;

   // Leaves the caller at the start of cycle T (in_st high)
   task automatic start_frame();
      frame_base = in_st_total;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("fetch_busy", 32'(busy), 32'h1);
      check("fetch_done_cleared", 32'(done), 32'h0);
      check("fetch_timeout_cleared", 32'(timeout), 32'h0);
      check("fetch_img_addr", 32'(img_addr), 32'h0);
      check("fetch_in_st", 32'(in_st), 32'h0);
      tick();
      check("send_in_st", 32'(in_st), 32'h1);
   endtask

   task automatic wait_done(input int budget);
      int i = 0;
      while (!done && i < budget) begin
         tick();
         i++;
      end
      check("done_within_budget", 32'(done), 32'h1);
      check("done_busy_low", 32'(busy), 32'h0);
      check("done_no_timeout", 32'(timeout), 32'h0);
      check("in_st_pulses", in_st_total - frame_base, 1);
   endtask

   task automatic readback();
      for (int k = 0; k < N_OUT; k++) begin
         res_addr = 6'(k);
         tick();
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty[%0d]: got no expected entry, required one", k);
         end else begin
            check($sformatf("res_rdata[%0d]", k), 32'(res_rdata), 32'(sb.pop_front()));
         end
      end
   endtask

   typedef struct {
      int          mode;
      int          delay;
      bit          has_exp;
      logic [15:0] exp0;
      logic [15:0] exp35;
   } frame_vec_t;

   frame_vec_t vecs [3];

   initial begin
      vecs[0] = '{mode: 0, delay: 0, has_exp: 1'b1, exp0: 16'h0480, exp35: 16'h1B00};
      vecs[1] = '{mode: 1, delay: 3, has_exp: 1'b1, exp0: 16'h0800, exp35: 16'h0800};
      vecs[2] = '{mode: 2, delay: 7, has_exp: 1'b0, exp0: 16'h0000, exp35: 16'h0000};

      rst      = 1'b1;
      start    = 1'b0;
      res_addr = '0;
      fill_img(0);
      tick(3);
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_done", 32'(done), 32'h0);
      check("reset_timeout", 32'(timeout), 32'h0);
      check("reset_in_st", 32'(in_st), 32'h0);
      check("reset_din", 32'(din), 32'h0);
      check("reset_img_addr", 32'(img_addr), 32'h0);
      rst = 1'b0;
      tick();

      // Table-driven frames with exact completion timing
      for (int i = 0; i < 3; i++) begin
         fill_img(vecs[i].mode);
         push_expected();
         eng_delay = vecs[i].delay;
         start_frame();
         tick(N_IN + 1 + vecs[i].delay + N_OUT);
         check($sformatf("vec%0d_done_not_early", i), 32'(done), 32'h0);
         check($sformatf("vec%0d_busy_in_capture", i), 32'(busy), 32'h1);
         tick();
         check($sformatf("vec%0d_done_edge", i), 32'(done), 32'h1);
         check($sformatf("vec%0d_busy_edge", i), 32'(busy), 32'h0);
         check($sformatf("vec%0d_in_st_pulses", i), in_st_total - frame_base, 1);
         readback();
         if (vecs[i].has_exp) begin
            res_addr = 6'd0;
            tick();
            check($sformatf("vec%0d_res0", i), 32'(res_rdata), 32'(vecs[i].exp0));
            res_addr = 6'd35;
            tick();
            check($sformatf("vec%0d_res35", i), 32'(res_rdata), 32'(vecs[i].exp35));
         end
      end

      res_addr = 6'd36;
      tick();
      check("res_addr_36_zero", 32'(res_rdata), 32'h0);
      res_addr = 6'd63;
      tick();
      check("res_addr_63_zero", 32'(res_rdata), 32'h0);

      // Engine silent: timeout exactly TIMEOUT cycles after WAIT entry
      eng_respond = 1'b0;
      fill_img(1);
      start_frame();
      tick(N_IN + 1 + TIMEOUT - 1);
      check("timeout_not_early", 32'(timeout), 32'h0);
      check("busy_before_timeout", 32'(busy), 32'h1);
      tick();
      check("timeout_set", 32'(timeout), 32'h1);
      check("timeout_busy_low", 32'(busy), 32'h0);
      check("timeout_done_low", 32'(done), 32'h0);
      eng_respond = 1'b1;

      // start during SEND and CAPTURE is ignored
      fill_img(2);
      push_expected();
      eng_delay = 3;
      start_frame();
      tick(10);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(67);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(200);
      tick(5);
      check("done_sticky", 32'(done), 32'h1);
      readback();

      // Second start after done starts a fresh frame
      fill_img(0);
      push_expected();
      eng_delay = 0;
      start_frame();
      wait_done(200);
      readback();

      // Reset mid-SEND at pixel 20
      fill_img(2);
      push_expected();
      start_frame();
      tick(20);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_in_st", 32'(in_st), 32'h0);
      check("midrst_din", 32'(din), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      check("midrst_img_addr", 32'(img_addr), 32'h0);
      sb.delete();

      // rst and start in the same cycle: rst wins
      rst   = 1'b1;
      start = 1'b1;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      check("rst_start_busy", 32'(busy), 32'h0);
      tick();
      check("rst_start_no_in_st", 32'(in_st), 32'h0);
      check("rst_start_still_idle", 32'(busy), 32'h0);

      push_expected();
      start_frame();
      wait_done(200);
      readback();

      // Spurious out_st during SEND is ignored
      fill_img(2);
      push_expected();
      eng_delay = 4;
      spur_rx   = 30;
      start_frame();
      wait_done(300);
      spur_rx = -1;
      readback();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
